alu_seq: RTL and testbench

Parametrised, pipelined successor to the datapath ALU for the rv32 core: all base-integer operations complete in one registered cycle, and a new iterative multiply/divide unit covers the RV32M instructions. Operands arrive through a valid/ready handshake from the execute stage. Results, with Z/N flags, return as a one-cycle `out_valid` pulse. Sits between the register-file/immediate operand mux and the writeback path. Execute stalls on `in_ready` low.

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Pipelined integer ALU: single-cycle base ops plus an iterative radix-2
// multiply / restoring divide unit for the RV32M group, behind a valid/ready handshake.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [4:0]       fop,
  input  logic [WIDTH-1:0] rda,
  input  logic [WIDTH-1:0] rdb,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SRL    = 5'd3;
  localparam logic [4:0] OP_SRA    = 5'd4;
  localparam logic [4:0] OP_AND    = 5'd5;
  localparam logic [4:0] OP_OR     = 5'd6;
  localparam logic [4:0] OP_XOR    = 5'd7;
  localparam logic [4:0] OP_IMM    = 5'd8;
  localparam logic [4:0] OP_MUL    = 5'd9;
  localparam logic [4:0] OP_MULH   = 5'd10;
  localparam logic [4:0] OP_MULHSU = 5'd11;
  localparam logic [4:0] OP_MULHU  = 5'd12;
  localparam logic [4:0] OP_DIV    = 5'd13;
  localparam logic [4:0] OP_DIVU   = 5'd14;
  localparam logic [4:0] OP_REM    = 5'd15;
  localparam logic [4:0] OP_REMU   = 5'd16;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               in_ready_q, out_valid_q, z_q, n_q;
  logic [WIDTH-1:0]   result_q;
  logic [4:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mag_q;
  logic               negq_q, negr_q, div0_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign Z         = z_q;
  assign N         = n_q;

  logic accept, is_multi, is_div_in;
  assign accept    = in_valid && in_ready_q && !flush;
  assign is_multi  = (fop >= OP_MUL) && (fop <= OP_REMU);
  assign is_div_in = (fop >= OP_DIV) && (fop <= OP_REMU);

  // Single-cycle datapath
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  assign shamt = rdb[SHW-1:0];

  always_comb begin
    sc_res = '0;
    case (fop)
      OP_ADD: sc_res = rda + rdb;
      OP_SUB: sc_res = rda - rdb;
      OP_SLL: sc_res = rda << shamt;
      OP_SRL: sc_res = rda >> shamt;
      OP_SRA: sc_res = $signed(rda) >>> shamt;
      OP_AND: sc_res = rda & rdb;
      OP_OR:  sc_res = rda | rdb;
      OP_XOR: sc_res = rda ^ rdb;
      OP_IMM: sc_res = rdb;
      default: sc_res = '0;
    endcase
  end

  // Operand conditioning: the iterative core works on magnitudes only
  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign a_sgn = (fop == OP_MULH) || (fop == OP_MULHSU) || (fop == OP_DIV) || (fop == OP_REM);
  assign b_sgn = (fop == OP_MULH) || (fop == OP_DIV) || (fop == OP_REM);
  assign a_neg = a_sgn && rda[WIDTH-1];
  assign b_neg = b_sgn && rdb[WIDTH-1];
  assign abs_a = a_neg ? -rda : rda;
  assign abs_b = b_neg ? -rdb : rdb;

  // One iteration step. Multiply: add-then-shift-right with multiplier in the
  // low half. Divide: shift {rem,dividend} left and try-subtract the divisor.
  logic             is_div_q;
  logic [WIDTH:0]   mul_sum, rem_sh, diff;
  logic             ge;
  logic [2*WIDTH-1:0] acc_step;
  assign is_div_q = (op_q >= OP_DIV);

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, mag_q};
    ge       = !diff[WIDTH];
    acc_step = '0;
    if (is_div_q)
      acc_step = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    else
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Sign fix-up; divide-by-zero quotient is forced to all ones regardless of sign
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fin_res;
  always_comb begin
    prod    = negq_q ? -acc_q : acc_q;
    quo     = div0_q ? '1 : (negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem     = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fin_res = '0;
    case (op_q)
      OP_MUL:                       fin_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fin_res = quo;
      OP_REM, OP_REMU:              fin_res = rem;
      default:                      fin_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      op_q        <= '0;
      acc_q       <= '0;
      mag_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (flush) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        in_ready_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              if (is_multi) begin
                op_q       <= fop;
                acc_q      <= {{WIDTH{1'b0}}, (is_div_in ? abs_a : abs_b)};
                mag_q      <= is_div_in ? abs_b : abs_a;
                negq_q     <= a_neg ^ b_neg;
                negr_q     <= a_neg;
                div0_q     <= (rdb == '0);
                cnt_q      <= '0;
                in_ready_q <= 1'b0;
                state_q    <= RUN;
              end else begin
                result_q    <= sc_res;
                z_q         <= (sc_res == '0);
                n_q         <= sc_res[WIDTH-1];
                out_valid_q <= 1'b1;
              end
            end
          end
          RUN: begin
            acc_q <= acc_step;
            if (cnt_q == CW'(WIDTH-1)) begin
              cnt_q   <= '0;
              state_q <= FIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          FIN: begin
            result_q    <= fin_res;
            z_q         <= (fin_res == '0);
            n_q         <= fin_res[WIDTH-1];
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed table plus corner-case sequences for alu_seq; a 16-bit instance
// shares the stimulus for the randomized reference-model sweep.
module tb_alu_seq;

  logic        clk, rst, in_valid, flush;
  logic [4:0]  fop;
  logic [31:0] rda, rdb;
  logic        in_ready32, out_valid32, z32o, n32o;
  logic [31:0] result32;
  logic        in_ready16, out_valid16, z16o, n16o;
  logic [15:0] result16;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .flush(flush),
    .fop(fop), .rda(rda), .rdb(rdb), .out_valid(out_valid32), .result(result32),
    .Z(z32o), .N(n32o));

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .flush(flush),
    .fop(fop), .rda(rda[15:0]), .rdb(rdb[15:0]), .out_valid(out_valid16), .result(result16),
    .Z(z16o), .N(n16o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SRL = 5'd3, SRA = 5'd4;
  localparam logic [4:0] AND_ = 5'd5, OR_ = 5'd6, XOR_ = 5'd7, IMM = 5'd8;
  localparam logic [4:0] MUL = 5'd9, MULH = 5'd10, MULHSU = 5'd11, MULHU = 5'd12;
  localparam logic [4:0] DIV = 5'd13, DIVU = 5'd14, REM = 5'd15, REMU = 5'd16;

  // Independent reference: native 64-bit arithmetic at width w
  function automatic logic [31:0] model(input int w, input logic [4:0] op,
                                        input logic [31:0] a0, input logic [31:0] b0);
    logic [63:0] m, ua, ub, p;
    longint sa, sb, mn;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a0} & m;
    ub = {32'd0, b0} & m;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    mn = -(longint'(1) << (w - 1));
    sh = int'(ub) & (w - 1);
    p  = 64'd0;
    case (op)
      ADD:    p = ua + ub;
      SUB:    p = ua - ub;
      SLL:    p = ua << sh;
      SRL:    p = ua >> sh;
      SRA:    p = sa >>> sh;
      AND_:   p = ua & ub;
      OR_:    p = ua | ub;
      XOR_:   p = ua ^ ub;
      IMM:    p = ub;
      MUL:    p = ua * ub;
      MULH:   p = (sa * sb) >> w;
      MULHSU: p = (sa * longint'(ub)) >> w;
      MULHU:  p = (ua * ub) >> w;
      DIV:    if (ub == 0) p = m; else if (sa == mn && sb == -1) p = ua; else p = sa / sb;
      DIVU:   if (ub == 0) p = m; else p = ua / ub;
      REM:    if (ub == 0) p = ua; else if (sa == mn && sb == -1) p = 0; else p = sa % sb;
      REMU:   if (ub == 0) p = ua; else p = ua % ub;
      default: p = 64'd0;
    endcase
    return 32'(p & m);
  endfunction

  // Results of the last do_op, per instance
  logic [31:0] r32;
  logic [15:0] r16;
  logic        zz32, nn32, zz16, nn16;
  int          cyc32, busy32, pulses32, cyc16, busy16;

  // Issue one op, then watch 40 cycles; cycle c is the c-th falling edge after the accept edge
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; fop = op; rda = a; rdb = b;
    @(negedge clk);
    in_valid = 1'b0;
    cyc32 = 0; busy32 = 0; pulses32 = 0; cyc16 = 0; busy16 = 0;
    r32 = '0; r16 = '0; zz32 = 0; nn32 = 0; zz16 = 0; nn16 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid32) begin
        pulses32++;
        if (cyc32 == 0) begin cyc32 = c; r32 = result32; zz32 = z32o; nn32 = n32o; end
      end
      if (out_valid16 && cyc16 == 0) begin cyc16 = c; r16 = result16; zz16 = z16o; nn16 = n16o; end
      if (!in_ready32) busy32++;
      if (!in_ready16) busy16++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, res;
    logic        z, n, multi;
  } vec_t;

  vec_t tbl[24];
  logic [31:0] last_exp;
  int          cnt;

  initial begin
    tbl[0]  = '{ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{OR_,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{XOR_, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{IMM,  32'h00001234, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{MULHU,32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{MUL,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{MULHSU,32'hFFFFFFFF,32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{DIV,  32'h000004D2, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{REM,  32'h000004D2, 32'h00000000, 32'h000004D2, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b1};
    tbl[16] = '{REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{5'd20,32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{5'd31,32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{DIVU, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    tbl[23] = '{REMU, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; fop = '0; rda = '0; rdb = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", in_ready32, 1);
    chk("reset out_valid", out_valid32, 0);
    chk("reset result", result32, 0);
    chk("reset Z", z32o, 0);
    chk("reset N", n32o, 0);

    // Directed table: cycle counts are falling edges from the accept edge to out_valid
    for (int i = 0; i < 24; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d result", i), r32, tbl[i].res);
      chk($sformatf("vec%0d Z", i), zz32, tbl[i].z);
      chk($sformatf("vec%0d N", i), nn32, tbl[i].n);
      chk($sformatf("vec%0d latency", i), cyc32, tbl[i].multi ? 34 : 1);
      chk($sformatf("vec%0d in_ready low cycles", i), busy32, tbl[i].multi ? 33 : 0);
      chk($sformatf("vec%0d pulses", i), pulses32, 1);
    end
    last_exp = tbl[23].res;

    // Flush a DIVU at iteration 10
    @(negedge clk);
    in_valid = 1'b1; fop = DIVU; rda = 32'd1000; rdb = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush in_ready", in_ready32, 1);
    chk("flush out_valid", out_valid32, 0);
    chk("flush result hold", result32, last_exp);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin if (out_valid32) cnt++; @(negedge clk); end
    chk("flush no late out_valid", cnt, 0);

    // flush with in_valid in the same cycle: not accepted
    in_valid = 1'b1; fop = ADD; rda = 32'd1; rdb = 32'd1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush+valid out_valid", out_valid32, 0);
    chk("flush+valid result hold", result32, last_exp);

    // DIVU, then ADD offered in the out_valid cycle
    in_valid = 1'b1; fop = DIVU; rda = 32'd100; rdb = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid32 && cnt < 40) begin @(negedge clk); cnt++; end
    chk("b2b divu done", out_valid32, 1);
    chk("b2b divu result", result32, 32'd14);
    chk("b2b in_ready with out_valid", in_ready32, 1);
    in_valid = 1'b1; fop = ADD; rda = 32'd2; rdb = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b add out_valid", out_valid32, 1);
    chk("b2b add result", result32, 32'd5);

    // Single-cycle ops every cycle
    in_valid = 1'b1; fop = ADD; rda = 32'd1; rdb = 32'd2;
    @(negedge clk);
    chk("stream add", {out_valid32, result32}, {1'b1, 32'd3});
    fop = SUB; rda = 32'd10; rdb = 32'd4;
    @(negedge clk);
    chk("stream sub", {out_valid32, result32}, {1'b1, 32'd6});
    fop = XOR_; rda = 32'hF0; rdb = 32'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stream xor", {out_valid32, result32}, {1'b1, 32'hFF});
    @(negedge clk);
    chk("stream single pulse", out_valid32, 0);

    // Asynchronous reset in the middle of a MUL
    in_valid = 1'b1; fop = MUL; rda = 32'd7; rdb = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst in_ready", in_ready32, 1);
    chk("async rst out_valid", out_valid32, 0);
    chk("async rst result", result32, 0);
    chk("async rst Z/N", {z32o, n32o}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin if (out_valid32) cnt++; @(negedge clk); end
    chk("rst no out_valid", cnt, 0);

    // in_valid held through a busy MUL must not be taken twice
    in_valid = 1'b1; fop = MUL; rda = 32'd6; rdb = 32'd7;
    cnt = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (out_valid32) begin
        cnt++;
        chk("held mul latency", c, 34);
        chk("held mul result", result32, 32'd42);
        in_valid = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (out_valid32) cnt++; end
    chk("held mul pulses", cnt, 1);

    // All opcodes, random operands, both widths against the model
    for (int op = 0; op < 32; op++) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] a, b, e32, e16;
        a = $urandom;
        b = (k == 2) ? 32'd0 : $urandom;
        do_op(5'(op), a, b);
        e32 = model(32, 5'(op), a, b);
        e16 = model(16, 5'(op), a, b);
        chk($sformatf("sweep32 op%0d %h %h", op, a, b), r32, e32);
        chk($sformatf("sweep32 op%0d Z/N", op), {zz32, nn32}, {e32 == 0, e32[31]});
        chk($sformatf("sweep16 op%0d %h %h", op, a[15:0], b[15:0]), r16, e16[15:0]);
        chk($sformatf("sweep16 op%0d Z/N", op), {zz16, nn16}, {e16 == 0, e16[15]});
        chk($sformatf("sweep lat op%0d", op), {cyc32, cyc16},
            (op >= 9 && op <= 16) ? {32'd34, 32'd18} : {32'd1, 32'd1});
        chk($sformatf("sweep busy16 op%0d", op), busy16, (op >= 9 && op <= 16) ? 17 : 0);
        chk($sformatf("sweep pulses op%0d", op), pulses32, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
